mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter and select controller for the 8:1 single-bit `multiplexer` datapath.
- Shares the mux between 8 requesters, one per data input I0..I7.
- Drives the mux select lines S0..S2 and qualifies the muxed output with a valid/ready handshake to one downstream consumer.
- Sits directly beside the `multiplexer` instance in the ALU operand-steering path.

Parameters:
SEL_W, 3, select width; number of requesters N_REQ = 2**SEL_W (8 at default).
CNT_W, 16, width of the completed-transfer counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N_REQ  per-requester request; bit i requests mux input Ii.
out_ready  input  1  downstream accepts the current muxed bit.
gnt  output  N_REQ  one-hot grant; bit i means Ii is selected.
sel  output  SEL_W  mux select; sel[2] drives S0, sel[1] drives S1, sel[0] drives S2 (sel value i selects Ii).
out_valid  output  1  muxed output O0 is valid for the granted requester.
busy  output  1  grant currently held.
xfer_cnt  output  CNT_W  count of completed transfers (out_valid & out_ready).

Behaviour:
- Reset (rst=1 at a clk edge) clears all state: gnt=0, sel=0, out_valid=0, busy=0, xfer_cnt=0, FSM=IDLE, rr pointer=N_REQ-1, so requester 0 has highest priority first.
- All outputs are registered. There is no combinational path from req or out_ready to any output.

FSM states and transitions:
- IDLE: if any req bit is set, pick the first set bit searching upward (cyclically) from ptr+1. Register gnt, sel and out_valid=1, then go to GRANT. Latency is one cycle from req to gnt/out_valid.
- GRANT: hold gnt/sel/out_valid stable while out_ready=0.
- GRANT, transfer completes (out_valid & out_ready):
  - ptr := winner; xfer_cnt increments and wraps modulo 2**CNT_W.
  - Re-arbitrate in the same cycle among req with the winner's bit masked off.
  - If another request exists, register the new grant and stay in GRANT (back-to-back, no bubble).
  - If only the winner or nobody is requesting, go to IDLE; the winner is re-granted from IDLE the next cycle if its req is still high.
- Withdrawal: if the granted requester drops req while in GRANT without a transfer, the grant is revoked on the next edge. gnt=0, out_valid=0, ptr is unchanged, FSM goes to IDLE. Withdrawal takes precedence over nothing; a transfer in the same cycle counts as a completion.
- Fairness: any continuously asserted request is granted within N_REQ transfers.
- Simultaneous requests: round-robin order only; there is no fixed priority beyond the ptr position.
- Reset mid-transfer: everything is cleared immediately and the in-flight transfer is not counted.
- Invariants:
  - gnt is one-hot or zero.
  - sel equals the binary index of gnt; sel holds its last value when gnt=0.
  - busy = out_valid.

Optional Feature:
MUX_ARB_LOCK_EN:
- Defined: adds input port lock (1 bit). While lock=1 in GRANT, a completed transfer keeps the same grant; ptr and FSM are unchanged, and xfer_cnt still increments. This allows multi-beat bursts from one source. Normal arbitration resumes on the first transfer with lock=0. Withdrawal still revokes the grant.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux_arb_pkg: FSM state enum (IDLE, GRANT), N_REQ derivation, reset pointer constant.
- One natural sub-module: rr_pick. Combinational; takes req, mask and ptr, and returns a one-hot winner plus its index and an any flag. It is reused for both IDLE arbitration and same-cycle re-arbitration.

Test Plan:
- Reset, then req=0000_0001 with out_ready=1 -> next cycle gnt=0x01, sel=0, out_valid=1; after the transfer, xfer_cnt=1.
- req=0xFF held, out_ready=1 -> grants in order 0,1,...,7,0 with no idle cycles; sel tracks 0..7; xfer_cnt=8 after 8 transfers.
- req=0x90, out_ready=0 for 5 cycles -> gnt=0x10 (sel=4) stable for 5 cycles; out_ready=1 -> next grant gnt=0x80, sel=7.
- Granted requester 3 drops req before out_ready -> next cycle gnt=0, out_valid=0, xfer_cnt unchanged; the next arbitration still starts after the old ptr.
- Assert rst while in GRANT with out_ready=1 in the same cycle -> all outputs 0, xfer_cnt=0; the first post-reset grant with req=0xFF goes to requester 0.
- (MUX_ARB_LOCK_EN) req=0x06, lock=1 for 3 transfers -> gnt=0x02 for all 3, xfer_cnt=3; drop lock -> next grant 0x04.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the round-robin mux arbiter.
// FSM state encodings and requester-count derivation.
package mux_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int n_req(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic int rst_ptr(input int sel_w);
    return (1 << sel_w) - 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin picker: first eligible request above ptr, cyclically.
// Purely combinational; shared by idle arbitration and re-arbitration.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int SEL_W = 3,
  localparam int N = n_req(SEL_W)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     elig;
  logic [SEL_W-1:0] pos;

  assign elig = req & mask;

  // Scan from ptr+1 upward with natural wrap; ptr itself is last.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 1; k <= N; k++) begin
      pos = ptr + SEL_W'(k);
      if (!any && elig[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
    if (any) win[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select with valid/ready out.
// Optional MUX_ARB_LOCK_EN adds a lock input for multi-beat bursts.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16,
  localparam int N_REQ = n_req(SEL_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [N_REQ-1:0] p_mask;
  logic [SEL_W-1:0] p_ptr;
  logic [N_REQ-1:0] p_win;
  logic [SEL_W-1:0] p_idx;
  logic             p_any;
  logic             xfer;
  logic             held;
  logic             lock_hold;

  assign xfer = out_valid & out_ready;
  assign held = |(req & gnt);

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock & held;
`else
  assign lock_hold = 1'b0;
`endif

  // In GRANT the winner is masked and the scan starts just past it.
  assign p_mask = (state == ST_GRANT) ? ~gnt : '1;
  assign p_ptr  = (state == ST_GRANT) ? sel : ptr;

  rr_pick #(
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (req),
    .mask (p_mask),
    .ptr  (p_ptr),
    .win  (p_win),
    .idx  (p_idx),
    .any  (p_any)
  );

  // Grant FSM, pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= SEL_W'(rst_ptr(SEL_W));
      gnt       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (p_any) begin
            gnt       <= p_win;
            sel       <= p_idx;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            if (!lock_hold) begin
              ptr <= sel;
              if (p_any) begin
                gnt <= p_win;
                sel <= p_idx;
              end else begin
                gnt       <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end
            end
          end else if (!held) begin
            gnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
